pack_fifo: RTL and testbench

//   Parametrised width-packing FIFO, next generation of the nibble-to-byte FIFO.
//   - Accepts IN_W-bit beats and packs RATIO beats into one OUT_W = IN_W*RATIO word.
//   - Buffers DEPTH packed words and presents them first-word-fall-through.
//   - Adds occupancy count, almost-full/almost-empty flags and sticky over/underflow flags.
//   - Sits between a narrow producer and a word-wide consumer on one clock domain.

---
 rtl/pack_fifo.sv | 138 +++++++++++++
 tb/tb_pack_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pack_fifo.sv
// rtl/pack_fifo.sv - width-packing first-word-fall-through FIFO
//
// Packs RATIO narrow IN_W-bit beats into one OUT_W = IN_W*RATIO word and buffers
// DEPTH such words. Beat 0 occupies the least significant lane.
// Optional feature macro: PACK_FLUSH_EN (adds the flush input that pushes a
// partially filled word with its unfilled upper lanes zeroed).
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   data_in         input beat, accepted when input_enable && input_valid
//   input_valid     FIFO can take a beat (not full)
//   data_out        head word, 0 when empty
//   output_enable   pop the head, honoured when output_valid
//   output_valid    head word present
//   count           number of stored packed words
//   almost_full     count >= AF_LEVEL
//   almost_empty    count <= AE_LEVEL
//   over_err        sticky: beat offered while full
//   under_err       sticky: pop requested while empty
//   flush           (PACK_FLUSH_EN only) push the partial word now
module pack_fifo #(
    parameter int IN_W     = 4,
    parameter int RATIO    = 2,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 7,
    parameter int AE_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [IN_W-1:0]            data_in,
    input  logic                       input_enable,
    output logic                       input_valid,
    output logic [IN_W*RATIO-1:0]      data_out,
    input  logic                       output_enable,
    output logic                       output_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       over_err,
    output logic                       under_err
`ifdef PACK_FLUSH_EN
    ,
    input  logic                       flush
`endif
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int BW    = $clog2(RATIO);

    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [BW-1:0]    beat_cnt;
    logic [OUT_W-1:0] pack_reg;
    logic [OUT_W-1:0] assembled;
    logic             beat_acc;
    logic             last_beat;
    logic             flush_push;
    logic             push;
    logic             pop;

    assign input_valid  = (count != FULL_CNT);
    assign output_valid = (count != '0);
    assign almost_full  = (int'(count) >= AF_LEVEL);
    assign almost_empty = (int'(count) <= AE_LEVEL);
    assign data_out     = output_valid ? mem[rd_ptr] : '0;

    assign beat_acc  = input_enable && input_valid;
    assign last_beat = beat_acc && (beat_cnt == LAST_BEAT);
    assign pop       = output_enable && output_valid;

`ifdef PACK_FLUSH_EN
    // Flush only acts on a word that already holds at least one beat; when the
    // same-edge beat completes the word, last_beat already pushes it.
    assign flush_push = flush && (beat_cnt != '0) && input_valid;
`else
    assign flush_push = 1'b0;
`endif

    assign push = last_beat || flush_push;

    // Word as it would be after this edge's beat; upper lanes stay 0 until filled.
    always_comb begin
        assembled = pack_reg;
        if (beat_acc) begin
            assembled[beat_cnt*IN_W +: IN_W] = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            beat_cnt  <= '0;
            pack_reg  <= '0;
            over_err  <= 1'b0;
            under_err <= 1'b0;
        end else begin
            if (input_enable && !input_valid) begin
                over_err <= 1'b1;
            end
            if (output_enable && !output_valid) begin
                under_err <= 1'b1;
            end
            if (push) begin
                wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
                beat_cnt <= '0;
                pack_reg <= '0;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
                pack_reg <= assembled;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage is not reset; only words below count are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= assembled;
        end
    end

endmodule

// File: tb/tb_pack_fifo.sv
// tb/tb_pack_fifo.sv - directed self-checking bench for pack_fifo (default parameters)
module tb_pack_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data_in;
    logic       input_enable;
    logic       input_valid;
    logic [7:0] data_out;
    logic       output_enable;
    logic       output_valid;
    logic [3:0] count;
    logic       almost_full;
    logic       almost_empty;
    logic       over_err;
    logic       under_err;
`ifdef PACK_FLUSH_EN
    logic       flush;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pack_fifo dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_in       (data_in),
        .input_enable  (input_enable),
        .input_valid   (input_valid),
        .data_out      (data_out),
        .output_enable (output_enable),
        .output_valid  (output_valid),
        .count         (count),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .over_err      (over_err),
        .under_err     (under_err)
`ifdef PACK_FLUSH_EN
        ,
        .flush         (flush)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] d);
        data_in      = d;
        input_enable = 1'b1;
        tick();
        input_enable = 1'b0;
    endtask

    task automatic pop_one();
        output_enable = 1'b1;
        tick();
        output_enable = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int rd_exp;
        rst_n         = 1'b1;
        data_in       = '0;
        input_enable  = 1'b0;
        output_enable = 1'b0;
`ifdef PACK_FLUSH_EN
        flush         = 1'b0;
`endif
        #2;
        do_reset();

        // reset state
        check("rst_input_valid", input_valid, 1);
        check("rst_output_valid", output_valid, 0);
        check("rst_data_out", data_out, 8'h00);
        check("rst_count", count, 0);
        check("rst_almost_empty", almost_empty, 1);
        check("rst_almost_full", almost_full, 0);
        check("rst_over_err", over_err, 0);
        check("rst_under_err", under_err, 0);

        // 1: two beats form one word, beat 0 in the LSBs
        beat(4'h1);
        check("t1_partial_not_visible", output_valid, 0);
        beat(4'h0);
        check("t1_output_valid", output_valid, 1);
        check("t1_data_out", data_out, 8'h01);
        check("t1_count", count, 1);
        check("t1_almost_empty", almost_empty, 1);
        pop_one();
        check("t1_count_after_pop", count, 0);

        // 2: fill to DEPTH, then overflow attempt
        for (int i = 0; i < 14; i++) beat(4'h3);
        check("t2_count7", count, 7);
        check("t2_af_at7", almost_full, 1);
        check("t2_ae_at7", almost_empty, 0);
        beat(4'h3);
        beat(4'h3);
        check("t2_count8", count, 8);
        check("t2_input_valid", input_valid, 0);
        check("t2_almost_full", almost_full, 1);
        check("t2_over_err_before", over_err, 0);
        beat(4'h3);
        check("t2_over_err", over_err, 1);
        check("t2_count_held", count, 8);

        // 3: drain, then underflow attempt
        for (int i = 0; i < 8; i++) begin
            check("t3_data_out", data_out, 8'h33);
            pop_one();
        end
        check("t3_output_valid", output_valid, 0);
        check("t3_data_out_empty", data_out, 8'h00);
        check("t3_under_err_before", under_err, 0);
        pop_one();
        check("t3_under_err", under_err, 1);
        check("t3_count", count, 0);
        check("t3_over_err_sticky", over_err, 1);

        // 4: interleaved traffic across pointer wrap
        do_reset();
        check("t4_flags_cleared", {over_err, under_err}, 2'b00);
        rd_exp = 0;
        for (int w = 0; w < 20; w++) begin
            beat(4'(w));
            if (w >= 2) begin
                check("t4_data_out", data_out, 32'(rd_exp));
                rd_exp++;
                output_enable = 1'b1;
            end
            beat(4'(w >> 4));
            output_enable = 1'b0;
        end
        check("t4_count", count, 2);
        while (rd_exp < 20) begin
            check("t4_drain_data_out", data_out, 32'(rd_exp));
            rd_exp++;
            pop_one();
        end
        check("t4_empty", output_valid, 0);
        check("t4_no_errors", {over_err, under_err}, 2'b00);

        // 5: final beat and pop on the same edge at count=1
        beat(4'h5);
        beat(4'h4);
        check("t5_head", data_out, 8'h45);
        beat(4'h7);
        check("t5_count_mid", count, 1);
        data_in       = 4'h8;
        input_enable  = 1'b1;
        output_enable = 1'b1;
        tick();
        input_enable  = 1'b0;
        output_enable = 1'b0;
        check("t5_count_same", count, 1);
        check("t5_new_head", data_out, 8'h87);

        // 6: asynchronous reset mid-packing discards the partial word
        beat(4'hA);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_async_output_valid", output_valid, 0);
        check("t6_async_count", count, 0);
        check("t6_async_data_out", data_out, 8'h00);
        #1;
        rst_n = 1'b1;
        beat(4'h1);
        beat(4'h2);
        check("t6_data_out", data_out, 8'h21);
        check("t6_count", count, 1);

`ifdef PACK_FLUSH_EN
        pop_one();
        beat(4'h5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6f_data_out", data_out, 8'h05);
        check("t6f_count", count, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6f_idle_flush_count", count, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
